// File: rtl/bus_arb_dec_pkg.sv
// Shared definitions for the two-master bus arbiter / address decoder:
// arbiter states, slave indices and address map.
package bus_arb_dec_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GRANT_M0 = 2'd1,
    GRANT_M1 = 2'd2
  } arb_state_t;

  localparam logic [1:0] SLV_DMAC = 2'd0;
  localparam logic [1:0] SLV_ALU  = 2'd1;
  localparam logic [1:0] SLV_MEM  = 2'd2;
  localparam logic [1:0] SLV_NONE = 2'd3;

  localparam logic [15:0] DMAC_BASE     = 16'h0000;
  localparam logic [15:0] DMAC_LAST     = 16'h00FF;
  localparam logic [15:0] ALU_BASE      = 16'h0100;
  localparam logic [15:0] ALU_LAST      = 16'h01FF;
  localparam logic [15:0] MEM_BASE_DFLT = 16'h0200;
  localparam logic [15:0] MEM_LAST_DFLT = 16'h07FF;

endpackage

// File: rtl/bus_arb_dec_addr.sv
// Combinational address decoder: maps a 16-bit bus address to a slave index.
module bus_addr_dec
  import bus_arb_dec_pkg::*;
#(
  parameter logic [15:0] MEM_BASE = MEM_BASE_DFLT,
  parameter logic [15:0] MEM_LAST = MEM_LAST_DFLT
) (
  input  logic [15:0] address,
  output logic [1:0]  slv_idx
);

  // DMAC region starts at zero, so only its upper bound needs a compare.
  always_comb begin
    slv_idx = SLV_NONE;
    if (address <= DMAC_LAST)
      slv_idx = SLV_DMAC;
    else if (address >= ALU_BASE && address <= ALU_LAST)
      slv_idx = SLV_ALU;
    else if (address >= MEM_BASE && address <= MEM_LAST)
      slv_idx = SLV_MEM;
  end

endmodule

// File: rtl/bus_arb_dec.sv
// Two-master (host, DMAC) non-preemptive bus arbiter with a shared command
// path, address decode to three slaves and a registered read-return mux.
module bus_arb_dec
  import bus_arb_dec_pkg::*;
#(
  parameter logic [15:0] MEM_BASE = MEM_BASE_DFLT,
  parameter logic [15:0] MEM_LAST = MEM_LAST_DFLT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_wr,
  input  logic [15:0] m0_address,
  input  logic [31:0] m0_dout,
  input  logic        m1_req,
  input  logic        m1_wr,
  input  logic [15:0] m1_address,
  input  logic [31:0] m1_dout,
  output logic        m0_grant,
  output logic        m1_grant,
  output logic [31:0] m_din,
  output logic        s0_sel,
  output logic        s1_sel,
  output logic        s2_sel,
  output logic        s_wr,
  output logic [15:0] s_address,
  output logic [31:0] s_din,
  input  logic [31:0] s0_dout,
  input  logic [31:0] s1_dout,
  input  logic [31:0] s2_dout
);

  arb_state_t  state, state_nxt;
  logic        act_req, act_wr;
  logic [1:0]  slv_idx;
  logic [1:0]  idx_p1;
  logic        rd_p1;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // No preemption: the owner keeps the bus until it drops its request.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (m0_req)      state_nxt = GRANT_M0;
        else if (m1_req) state_nxt = GRANT_M1;
      end
      GRANT_M0: begin
        if (!m0_req) state_nxt = m1_req ? GRANT_M1 : IDLE;
      end
      GRANT_M1: begin
        if (!m1_req) state_nxt = m0_req ? GRANT_M0 : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    m0_grant = (state == GRANT_M0);
    m1_grant = (state == GRANT_M1);
  end

  always_comb begin
    act_req   = 1'b0;
    act_wr    = 1'b0;
    s_address = 16'h0000;
    s_din     = 32'h0;
    case (state)
      GRANT_M0: begin
        act_req   = m0_req;
        act_wr    = m0_wr;
        s_address = m0_address;
        s_din     = m0_dout;
      end
      GRANT_M1: begin
        act_req   = m1_req;
        act_wr    = m1_wr;
        s_address = m1_address;
        s_din     = m1_dout;
      end
      default: ;
    endcase
  end

  bus_addr_dec #(
    .MEM_BASE (MEM_BASE),
    .MEM_LAST (MEM_LAST)
  ) u_addr_dec (
    .address (s_address),
    .slv_idx (slv_idx)
  );

  always_comb begin
    s_wr   = act_req & act_wr;
    s0_sel = act_req & (slv_idx == SLV_DMAC);
    s1_sel = act_req & (slv_idx == SLV_ALU);
    s2_sel = act_req & (slv_idx == SLV_MEM);
  end

  // ---- stage p1: read return, independent of the grant in this cycle ----
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_p1  <= 1'b0;
      idx_p1 <= SLV_NONE;
    end else begin
      rd_p1  <= act_req & ~act_wr;
      idx_p1 <= slv_idx;
    end
  end

  always_comb begin
    m_din = 32'h0;
    if (rd_p1) begin
      case (idx_p1)
        SLV_DMAC: m_din = s0_dout;
        SLV_ALU:  m_din = s1_dout;
        SLV_MEM:  m_din = s2_dout;
        default:  m_din = 32'h0;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arb_dec.sv
// Bench for bus_arb_dec: directed scenarios with a queue of expected
// read-return values checked one cycle after each command.
module tb_bus_arb_dec;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m0_wr, m1_req, m1_wr;
  logic [15:0] m0_address, m1_address;
  logic [31:0] m0_dout, m1_dout;
  logic        m0_grant, m1_grant;
  logic [31:0] m_din;
  logic        s0_sel, s1_sel, s2_sel, s_wr;
  logic [15:0] s_address;
  logic [31:0] s_din;
  logic [31:0] s0_dout, s1_dout, s2_dout;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] sb[$];

  localparam logic [31:0] D0 = 32'hD0D0_0000;
  localparam logic [31:0] D2 = 32'hEEEE_0002;

  always #5 clk = ~clk;

  bus_arb_dec dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_address(m0_address), .m0_dout(m0_dout),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_address(m1_address), .m1_dout(m1_dout),
    .m0_grant(m0_grant), .m1_grant(m1_grant), .m_din(m_din),
    .s0_sel(s0_sel), .s1_sel(s1_sel), .s2_sel(s2_sel),
    .s_wr(s_wr), .s_address(s_address), .s_din(s_din),
    .s0_dout(s0_dout), .s1_dout(s1_dout), .s2_dout(s2_dout)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Ends the current cycle: checks the read return due now, queues the one due next.
  task automatic tick(input logic [31:0] exp_next);
    logic [31:0] e;
    @(negedge clk);
    chk("one_grant", {31'h0, m0_grant & m1_grant}, 32'h0);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("m_din", m_din, e);
    end
    sb.push_back(exp_next);
    @(posedge clk);
    #1;
  endtask

  task automatic drv0(input logic req, input logic wr, input logic [15:0] a, input logic [31:0] d);
    m0_req = req; m0_wr = wr; m0_address = a; m0_dout = d;
  endtask

  task automatic drv1(input logic req, input logic wr, input logic [15:0] a, input logic [31:0] d);
    m1_req = req; m1_wr = wr; m1_address = a; m1_dout = d;
  endtask

  function automatic logic [31:0] sels();
    return {29'h0, s2_sel, s1_sel, s0_sel};
  endfunction

  function automatic logic [31:0] grants();
    return {30'h0, m1_grant, m0_grant};
  endfunction

  typedef struct {
    logic [15:0] a;
    logic [31:0] sel;
    logic [31:0] din;
  } dec_vec_t;

  dec_vec_t dec_tbl[8];

  initial begin
    dec_tbl[0] = '{16'h0000, 32'd1, D0};
    dec_tbl[1] = '{16'h00FF, 32'd1, D0};
    dec_tbl[2] = '{16'h0100, 32'd2, 32'h0000_5A5A};
    dec_tbl[3] = '{16'h01FF, 32'd2, 32'h0000_5A5A};
    dec_tbl[4] = '{16'h0200, 32'd4, D2};
    dec_tbl[5] = '{16'h07FF, 32'd4, D2};
    dec_tbl[6] = '{16'h0800, 32'd0, 32'h0};
    dec_tbl[7] = '{16'hFFFF, 32'd0, 32'h0};

    reset = 1'b1;
    drv0(1'b0, 1'b0, 16'h0, 32'h0);
    drv1(1'b0, 1'b0, 16'h0, 32'h0);
    s0_dout = D0; s1_dout = 32'h0000_5A5A; s2_dout = D2;
    @(posedge clk); #1;
    tick(32'h0);
    reset = 1'b0;
    #1;
    chk("rst_grants", grants(), 32'h0);
    chk("rst_sels", sels(), 32'h0);
    chk("rst_s_wr", {31'h0, s_wr}, 32'h0);

    // host write to memory base
    drv0(1'b1, 1'b1, 16'h0200, 32'd1000000000);
    #1;
    chk("w_idle_grants", grants(), 32'h0);
    chk("w_idle_sels", sels(), 32'h0);
    tick(32'h0);
    chk("w_grant", grants(), 32'd1);
    chk("w_sels", sels(), 32'd4);
    chk("w_s_wr", {31'h0, s_wr}, 32'h1);
    chk("w_s_din", s_din, 32'd1000000000);
    chk("w_s_addr", {16'h0, s_address}, 32'h0000_0200);
    tick(32'h0);

    // address map boundaries, reads by the host while it holds the bus
    foreach (dec_tbl[i]) begin
      drv0(1'b1, 1'b0, dec_tbl[i].a, 32'h0);
      #1;
      chk("dec_sels", sels(), dec_tbl[i].sel);
      chk("dec_s_wr", {31'h0, s_wr}, 32'h0);
      tick(dec_tbl[i].din);
    end
    drv0(1'b0, 1'b0, 16'h0, 32'h0);
    #1;
    chk("rel_sels", sels(), 32'h0);
    tick(32'h0);
    chk("rel_idle", grants(), 32'h0);

    // simultaneous requests: host wins, DMAC follows with a read of ALU regs
    s1_dout = 32'h0000_1234;
    drv0(1'b1, 1'b0, 16'h0010, 32'h0);
    drv1(1'b1, 1'b0, 16'h0104, 32'h0);
    #1;
    tick(32'h0);
    chk("sim_grant_m0", grants(), 32'd1);
    chk("sim_sel_s0", sels(), 32'd1);
    tick(D0);
    drv0(1'b0, 1'b0, 16'h0, 32'h0);
    #1;
    chk("hand_still_m0", grants(), 32'd1);
    chk("hand_no_sel", sels(), 32'h0);
    tick(32'h0);
    chk("hand_grant_m1", grants(), 32'd2);
    chk("m1_sel_s1", sels(), 32'd2);
    chk("m1_s_addr", {16'h0, s_address}, 32'h0000_0104);
    tick(32'h0000_1234);
    drv1(1'b0, 1'b0, 16'h0, 32'h0);
    #1;
    tick(32'h0);
    chk("m1_rel_idle", grants(), 32'h0);

    // unmapped write then unmapped read by the host
    drv0(1'b1, 1'b1, 16'h0900, 32'hDEAD_BEEF);
    #1;
    tick(32'h0);
    chk("unm_w_sels", sels(), 32'h0);
    chk("unm_w_grant", grants(), 32'd1);
    tick(32'h0);
    drv0(1'b1, 1'b0, 16'h0900, 32'h0);
    #1;
    chk("unm_r_sels", sels(), 32'h0);
    tick(32'h0);
    drv0(1'b0, 1'b0, 16'h0, 32'h0);
    #1;
    tick(32'h0);

    // long host ownership: DMAC must wait, no preemption
    drv0(1'b1, 1'b1, 16'h0300, 32'h1111_0000);
    drv1(1'b1, 1'b0, 16'h0020, 32'h0);
    #1;
    tick(32'h0);
    for (int c = 0; c < 10; c++) begin
      chk("hold_m0", grants(), 32'd1);
      tick(32'h0);
    end
    drv0(1'b0, 1'b0, 16'h0, 32'h0);
    #1;
    chk("hold_drop_m0", grants(), 32'd1);
    tick(32'h0);
    chk("hold_pass_m1", grants(), 32'd2);
    chk("hold_m1_sel", sels(), 32'd1);
    tick(D0);

    // reset during a DMAC read: read return must be 0
    drv1(1'b1, 1'b0, 16'h0104, 32'h0);
    #1;
    chk("pre_rst_sel", sels(), 32'd2);
    reset = 1'b1;
    tick(32'h0);
    reset = 1'b0;
    #1;
    chk("rst_mid_grants", grants(), 32'h0);
    chk("rst_mid_sels", sels(), 32'h0);
    drv1(1'b0, 1'b0, 16'h0, 32'h0);
    #1;
    tick(32'h0);
    tick(32'h0);

    @(negedge clk);
    while (sb.size() > 0) begin
      logic [31:0] e;
      e = sb.pop_front();
      chk("m_din_tail", m_din, e);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
